// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: cycle states, opcode encodings and ALU selects.
package cpu_pkg;

   localparam int OPCODE_BITS = 4;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      HALT   = 2'd3
   } t_cycle;

   typedef enum logic [OPCODE_BITS-1:0] {
      OP_NOP   = 4'h0,
      OP_LDI   = 4'h1,
      OP_LD    = 4'h2,
      OP_ST    = 4'h3,
      OP_ADD   = 4'h4,
      OP_SUB   = 4'h5,
      OP_AND   = 4'h6,
      OP_OR    = 4'h7,
      OP_XOR   = 4'h8,
      OP_JMP   = 4'h9,
      OP_JZ    = 4'hA,
      OP_JC    = 4'hB,
      OP_ILL_C = 4'hC,
      OP_ILL_D = 4'hD,
      OP_ILL_E = 4'hE,
      OP_HALT  = 4'hF
   } t_opcode;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5
   } t_alu_op;

   // Loads pass the operand through so Z can come from the ALU zero detect.
   function automatic t_alu_op alu_op_of(input t_opcode op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU; carry is carry-out for ADD and borrow (acc < operand) for SUB.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int WORD_BITS = 8
) (
   input  logic [WORD_BITS-1:0] acc,
   input  logic [WORD_BITS-1:0] operand,
   input  t_alu_op              op,
   output logic [WORD_BITS-1:0] result,
   output logic                 carry,
   output logic                 zero
);

   logic [WORD_BITS:0] sum;
   logic [WORD_BITS:0] diff;

   assign sum  = {1'b0, acc} + {1'b0, operand};
   assign diff = {1'b0, acc} - {1'b0, operand};

   always_comb begin
      result = operand;
      carry  = 1'b0;
      case (op)
         ALU_ADD: begin
            result = sum[WORD_BITS-1:0];
            carry  = sum[WORD_BITS];
         end
         ALU_SUB: begin
            result = diff[WORD_BITS-1:0];
            carry  = diff[WORD_BITS];
         end
         ALU_AND: result = acc & operand;
         ALU_OR:  result = acc | operand;
         ALU_XOR: result = acc ^ operand;
         default: result = operand;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/cpu_acc.sv
// Multi-cycle accumulator CPU over one shared memory port (FETCH/DECODE/EXEC/HALT).
// Define CPU_TRAP_ILLEGAL_EN to halt on opcodes C..E and expose out_trap; otherwise they act as NOP.
module cpu_acc #(
   parameter int                   ADDR_BITS   = 8,
   parameter int                   WORD_BITS   = 8,
   parameter int                   OPCODE_BITS = 4,
   parameter logic [ADDR_BITS-1:0] RESET_PC    = '0
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 in_mem_ready,
   input  logic [WORD_BITS-1:0] in_mem_data,
   output logic                 out_mem_read,
   output logic                 out_mem_write,
   output logic [WORD_BITS-1:0] out_mem_data,
   output logic [ADDR_BITS-1:0] out_mem_addr,
   output logic [WORD_BITS-1:0] out_instr,
   output logic [WORD_BITS-1:0] out_acc,
   output logic [ADDR_BITS-1:0] out_pc,
   output logic                 out_halted
`ifdef CPU_TRAP_ILLEGAL_EN
   ,
   output logic                 out_trap
`endif
);

   import cpu_pkg::*;

   t_cycle               state;
   logic [1:0]           sub;
   logic [ADDR_BITS-1:0] pc;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [WORD_BITS-1:0] instr;
   logic [WORD_BITS-1:0] acc;
   logic [WORD_BITS-1:0] operand;
   logic [WORD_BITS-1:0] wdata;
   logic                 rd;
   logic                 wr;
   logic                 z;
   logic                 c;
   logic                 halted;
`ifdef CPU_TRAP_ILLEGAL_EN
   logic                 trap;
`endif

   t_opcode              opc;
   t_alu_op              alu_op;
   logic [ADDR_BITS-1:0] ea;
   logic [ADDR_BITS-1:0] pc_next;
   logic [WORD_BITS-1:0] alu_result;
   logic                 alu_carry;
   logic                 alu_zero;

   assign opc     = t_opcode'(instr[WORD_BITS-1 -: OPCODE_BITS]);
   assign alu_op  = alu_op_of(opc);
   assign ea      = ADDR_BITS'(operand);
   assign pc_next = pc + ADDR_BITS'(1);

   // The operand register doubles as the memory-data latch, so the ALU never sees in_mem_data directly.
   cpu_alu #(
      .WORD_BITS (WORD_BITS)
   ) u_alu (
      .acc     (acc),
      .operand (operand),
      .op      (alu_op),
      .result  (alu_result),
      .carry   (alu_carry),
      .zero    (alu_zero)
   );

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state    <= FETCH;
         sub      <= 2'd0;
         pc       <= RESET_PC;
         mem_addr <= '0;
         instr    <= '0;
         acc      <= '0;
         operand  <= '0;
         wdata    <= '0;
         rd       <= 1'b0;
         wr       <= 1'b0;
         z        <= 1'b0;
         c        <= 1'b0;
         halted   <= 1'b0;
`ifdef CPU_TRAP_ILLEGAL_EN
         trap     <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (sub == 2'd0) begin
                  mem_addr <= pc;
                  rd       <= 1'b1;
                  pc       <= pc_next;
                  sub      <= 2'd1;
               end else if (in_mem_ready) begin
                  instr <= in_mem_data;
                  rd    <= 1'b0;
                  sub   <= 2'd0;
                  state <= DECODE;
               end
            end

            DECODE: begin
               if (sub == 2'd0) begin
                  case (opc)
                     OP_NOP: state <= FETCH;
                     OP_HALT: begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end
                     OP_ILL_C, OP_ILL_D, OP_ILL_E: begin
`ifdef CPU_TRAP_ILLEGAL_EN
                        halted <= 1'b1;
                        trap   <= 1'b1;
                        state  <= HALT;
`else
                        state  <= FETCH;
`endif
                     end
                     default: begin
                        mem_addr <= pc;
                        rd       <= 1'b1;
                        pc       <= pc_next;
                        sub      <= 2'd1;
                     end
                  endcase
               end else if (in_mem_ready) begin
                  operand <= in_mem_data;
                  rd      <= 1'b0;
                  sub     <= 2'd0;
                  state   <= EXEC;
               end
            end

            EXEC: begin
               case (sub)
                  2'd0: begin
                     case (opc)
                        OP_LDI: begin
                           acc   <= alu_result;
                           z     <= alu_zero;
                           state <= FETCH;
                        end
                        OP_JMP: begin
                           pc    <= ea;
                           state <= FETCH;
                        end
                        OP_JZ: begin
                           if (z) pc <= ea;
                           state <= FETCH;
                        end
                        OP_JC: begin
                           if (c) pc <= ea;
                           state <= FETCH;
                        end
                        OP_ST: begin
                           mem_addr <= ea;
                           wdata    <= acc;
                           wr       <= 1'b1;
                           sub      <= 2'd1;
                        end
                        OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                           mem_addr <= ea;
                           rd       <= 1'b1;
                           sub      <= 2'd1;
                        end
                        default: state <= FETCH;
                     endcase
                  end
                  2'd1: begin
                     if (in_mem_ready) begin
                        if (opc != OP_ST) operand <= in_mem_data;
                        rd  <= 1'b0;
                        wr  <= 1'b0;
                        sub <= 2'd2;
                     end
                  end
                  default: begin
                     // Retire: the memory operand is now registered in operand.
                     if (opc != OP_ST) begin
                        acc <= alu_result;
                        z   <= alu_zero;
                        if (alu_op != ALU_PASS) c <= alu_carry;
                     end
                     sub   <= 2'd0;
                     state <= FETCH;
                  end
               endcase
            end

            HALT: begin
               rd <= 1'b0;
               wr <= 1'b0;
            end

            default: state <= HALT;
         endcase
      end
   end

   assign out_mem_read  = rd;
   assign out_mem_write = wr;
   assign out_mem_data  = wdata;
   assign out_mem_addr  = mem_addr;
   assign out_instr     = instr;
   assign out_acc       = acc;
   assign out_pc        = pc;
   assign out_halted    = halted;
`ifdef CPU_TRAP_ILLEGAL_EN
   assign out_trap      = trap;
`endif

endmodule

// File: tb/tb_cpu_acc.sv
// Bench for cpu_acc: an instruction-level model predicts every bus request, its timing and the final state.
`timescale 1ns/1ps
module tb_cpu_acc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] rdata = 8'h00;
   logic       rd, wr, halted;
   logic [7:0] wdata, addr, instr, acc, pc;
`ifdef CPU_TRAP_ILLEGAL_EN
   logic       trap;
`endif

   always #5 clk = ~clk;

   cpu_acc dut (
      .in_clk        (clk),
      .in_rst        (rst),
      .in_mem_ready  (ready),
      .in_mem_data   (rdata),
      .out_mem_read  (rd),
      .out_mem_write (wr),
      .out_mem_data  (wdata),
      .out_mem_addr  (addr),
      .out_instr     (instr),
      .out_acc       (acc),
      .out_pc        (pc),
      .out_halted    (halted)
`ifdef CPU_TRAP_ILLEGAL_EN
      ,
      .out_trap      (trap)
`endif
   );

   typedef struct {
      bit         wr;
      bit         fetch;
      bit         last;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] acc;
      logic [7:0] instr;
      int         lat;
   } req_t;

   req_t       expq[$];
   logic [7:0] mem[256];
   logic [7:0] init_mem[256];
   logic [7:0] model_mem[256];
   logic [7:0] m_acc, m_pc;
   bit         m_halted, m_trap;
   int         checks = 0;
   int         passed = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   // Instruction-level interpreter: emits the bus requests each instruction must make, in order.
   task automatic model_run(input int max_instr);
      logic [7:0] pcm, accm, ins, opd, v;
      logic [8:0] s;
      bit         z, c;
      int         prev_lat, n;
      model_mem = init_mem;
      pcm = 8'h00; accm = 8'h00; z = 0; c = 0;
      m_halted = 0; m_trap = 0; prev_lat = 0; n = 0;
      expq.delete();
      while (!m_halted) begin
         if (n == max_instr) begin
            expq.push_back('{wr:1'b0, fetch:1'b1, last:1'b1, addr:pcm, data:8'h00, acc:accm, instr:8'h00, lat:prev_lat});
            break;
         end
         n++;
         ins = model_mem[pcm];
         expq.push_back('{wr:1'b0, fetch:1'b1, last:1'b0, addr:pcm, data:8'h00, acc:accm, instr:8'h00, lat:prev_lat});
         pcm = pcm + 8'h01;
         prev_lat = 3;
         case (ins[7:4])
            4'h0: ;
            4'hF: m_halted = 1;
            4'hC, 4'hD, 4'hE: begin
`ifdef CPU_TRAP_ILLEGAL_EN
               m_halted = 1;
               m_trap = 1;
`endif
            end
            default: begin
               expq.push_back('{wr:1'b0, fetch:1'b0, last:1'b0, addr:pcm, data:8'h00, acc:accm, instr:ins, lat:0});
               opd = model_mem[pcm];
               pcm = pcm + 8'h01;
               prev_lat = 5;
               if (ins[7:4] >= 4'h2 && ins[7:4] <= 4'h8) begin
                  prev_lat = 7;
                  expq.push_back('{wr:(ins[7:4] == 4'h3), fetch:1'b0, last:1'b0, addr:opd, data:accm, acc:accm, instr:ins, lat:0});
               end
               v = model_mem[opd];
               case (ins[7:4])
                  4'h1: accm = opd;
                  4'h2: accm = v;
                  4'h3: model_mem[opd] = accm;
                  4'h4: begin s = {1'b0, accm} + {1'b0, v}; c = s[8]; accm = s[7:0]; end
                  4'h5: begin c = (accm < v); accm = accm - v; end
                  4'h6: begin c = 0; accm = accm & v; end
                  4'h7: begin c = 0; accm = accm | v; end
                  4'h8: begin c = 0; accm = accm ^ v; end
                  4'h9: pcm = opd;
                  4'hA: if (z) pcm = opd;
                  4'hB: if (c) pcm = opd;
                  default: ;
               endcase
               if (ins[7:4] inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}) z = (accm == 8'h00);
            end
         endcase
      end
      m_acc = accm;
      m_pc = pcm;
   endtask

   // Memory responder and per-cycle bus checker.
   bit         active = 0;
   bit         holding = 0;
   bit         h_wr;
   logic [7:0] h_addr, h_data;
   int         cyc = 0;
   int         last_fetch = -1;
   int         waits_acc = 0;
   int         wait_left = 0;
   int         cur_d = 0;
   int         dly = 0;
   req_t       e;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         ready = 1'b0;
         if (active) begin
            check("strobe_exclusive", {31'd0, rd & wr}, 32'd0);
            if (rd || wr) begin
               if (!holding) begin
                  if (expq.size() == 0) begin
                     check("extra_request", {24'd0, addr}, 32'hFFFF);
                     active = 0;
                  end else begin
                     e = expq.pop_front();
                     check("req_kind", {31'd0, wr}, {31'd0, e.wr});
                     check("req_addr", {24'd0, addr}, {24'd0, e.addr});
                     if (e.wr) check("req_wdata", {24'd0, wdata}, {24'd0, e.data});
                     if (e.fetch) begin
                        check("fetch_acc", {24'd0, acc}, {24'd0, e.acc});
                        check("fetch_pc", {24'd0, pc}, {24'd0, e.addr + 8'h01});
                        if (last_fetch >= 0)
                           check("latency", cyc - last_fetch, e.lat + waits_acc);
                        last_fetch = cyc;
                     end else begin
                        check("req_instr", {24'd0, instr}, {24'd0, e.instr});
                     end
                     if (e.last) begin
                        active = 0;
                     end else begin
                        cur_d = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
                        waits_acc = e.fetch ? cur_d : waits_acc + cur_d;
                        wait_left = cur_d;
                        holding = 1;
                        h_addr = addr;
                        h_wr = wr;
                        h_data = wdata;
                     end
                  end
               end else begin
                  check("hold_addr", {24'd0, addr}, {24'd0, h_addr});
                  check("hold_kind", {31'd0, wr}, {31'd0, h_wr});
                  if (h_wr) check("hold_wdata", {24'd0, wdata}, {24'd0, h_data});
               end
               if (active && holding) begin
                  if (wait_left == 0) begin
                     ready = 1'b1;
                     if (rd) rdata = mem[addr];
                     else mem[addr] = wdata;
                     holding = 0;
                  end else begin
                     wait_left--;
                  end
               end
            end else if (holding) begin
               check("strobe_dropped_early", 32'd0, 32'd1);
               holding = 0;
            end
         end
      end
   end

   task automatic run_prog(input string name, input int max_instr, input int d);
      int nmis;
      active = 0;
      rst = 1'b1;
      dly = d;
      mem = init_mem;
      model_run(max_instr);
      repeat (2) @(negedge clk);
      check("rst_pc", {24'd0, pc}, 32'h00);
      check("rst_acc", {24'd0, acc}, 32'h00);
      check("rst_instr", {24'd0, instr}, 32'h00);
      check("rst_addr", {24'd0, addr}, 32'h00);
      check("rst_wdata", {24'd0, wdata}, 32'h00);
      check("rst_strobes", {30'd0, rd, wr}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      holding = 0; last_fetch = -1; waits_acc = 0;
      rst = 1'b0;
      active = 1;
      for (int i = 0; i < 20000; i++) begin
         if (m_halted ? (halted === 1'b1 && expq.size() == 0) : !active) break;
         @(negedge clk);
      end
      if (m_halted ? !(halted === 1'b1 && expq.size() == 0) : active) begin
         $display("FAIL %s: timeout, %0d requests outstanding", name, expq.size());
         checks++;
      end
      if (m_halted) begin
         check("halt_flag", {31'd0, halted}, 32'd1);
         check("halt_pc", {24'd0, pc}, {24'd0, m_pc});
         check("halt_acc", {24'd0, acc}, {24'd0, m_acc});
`ifdef CPU_TRAP_ILLEGAL_EN
         check("trap_flag", {31'd0, trap}, {31'd0, m_trap});
`endif
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_quiet", {30'd0, rd, wr}, 32'd0);
         end
      end
      nmis = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) nmis++;
      check("mem_image", nmis, 0);
      active = 0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
   endtask

   initial begin
      // Reset while a fetch is outstanding and ready is held low.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("midread_rd", {31'd0, rd}, 32'd1);
      check("midread_addr", {24'd0, addr}, 32'h00);
      rst = 1'b1;
      @(negedge clk);
      check("midread_rst_strobes", {30'd0, rd, wr}, 32'd0);
      check("midread_rst_pc", {24'd0, pc}, 32'h00);

      // LDI F0; ADD [20]; JC 10 -> carry taken to HALT at 0x10.
      clear_mem();
      init_mem[0] = 8'h10; init_mem[1] = 8'hF0; init_mem[2] = 8'h40; init_mem[3] = 8'h20;
      init_mem[4] = 8'hB0; init_mem[5] = 8'h10; init_mem[8'h10] = 8'hF0; init_mem[8'h20] = 8'h20;
      run_prog("jc_carry", 50, 0);
      check("model_jc_acc", {24'd0, m_acc}, 32'h10);
      check("jc_acc", {24'd0, acc}, 32'h10);
      check("jc_pc", {24'd0, pc}, 32'h11);

      // Same program with three wait cycles on every access.
      run_prog("jc_slow", 50, 3);
      check("slow_acc", {24'd0, acc}, 32'h10);

      // LDI 5; SUB [21]; JZ 30; ST [22] -> zero jump skips the store.
      clear_mem();
      init_mem[0] = 8'h10; init_mem[1] = 8'h05; init_mem[2] = 8'h50; init_mem[3] = 8'h21;
      init_mem[4] = 8'hA0; init_mem[5] = 8'h30; init_mem[6] = 8'h30; init_mem[7] = 8'h22;
      init_mem[8'h21] = 8'h05; init_mem[8'h22] = 8'h77; init_mem[8'h30] = 8'hF0;
      run_prog("jz_zero", 50, 0);
      check("jz_acc", {24'd0, acc}, 32'h00);
      check("jz_pc", {24'd0, pc}, 32'h31);
      check("jz_no_store", {24'd0, mem[8'h22]}, 32'h77);

      // NOPs up to a HALT at 0xFF: pc wraps to 0.
      clear_mem();
      init_mem[8'hFF] = 8'hF0;
      run_prog("halt_wrap", 300, 0);
      check("wrap_pc", {24'd0, pc}, 32'h00);

      // Illegal opcode D followed by LDI 33; HALT.
      clear_mem();
      init_mem[0] = 8'hD0; init_mem[1] = 8'h10; init_mem[2] = 8'h33; init_mem[3] = 8'hF0;
      run_prog("illegal", 50, 0);
`ifdef CPU_TRAP_ILLEGAL_EN
      check("ill_pc", {24'd0, pc}, 32'h01);
      check("ill_trap", {31'd0, trap}, 32'd1);
`else
      check("ill_acc", {24'd0, acc}, 32'h33);
      check("ill_pc", {24'd0, pc}, 32'h04);
`endif

      // Random memory images with random wait states.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
         run_prog("random", 40, -1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
